pim_ctrl: RTL and testbench

Sequencer and access arbiter for one bit-serial PIM macro. Accepts weight reads and writes on a memory port and input-vector MAC jobs on a compute port. It round-robins between the two, drives the macro's address, data, write-enable, processing-enable and row-wordline inputs, and returns each MAC result on a valid/ready response port. Sits between the AXI-facing register and DMA logic and the PIM macro instance.

---
 rtl/pim_ctrl_pkg.sv | 19 +
 rtl/pim_ctrl_arb.sv | 32 +++
 rtl/pim_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pim_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_ctrl_pkg.sv
// Shared types and fixed phase lengths for the PIM macro sequencer.
package pim_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RD_RESP,
    S_PREP,
    S_MAC,
    S_DRAIN,
    S_RESP
  } state_e;

  localparam int unsigned PREP_CYCLES  = 1;
  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/pim_ctrl_arb.sv
// Two-way round-robin between the memory port and the compute port.
module pim_ctrl_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic mem_valid,
  input  logic in_valid,
  output logic mem_ready,
  output logic in_ready,
  output logic mem_grant,
  output logic in_grant
);

  logic prio_mem_q, prio_mem_d;

  assign mem_ready = idle && (!in_valid || prio_mem_q);
  assign in_ready  = idle && (!mem_valid || !prio_mem_q);
  assign mem_grant = mem_valid && mem_ready;
  assign in_grant  = in_valid && in_ready;

  always_comb begin
    prio_mem_d = prio_mem_q;
    if (mem_grant)     prio_mem_d = 1'b0;
    else if (in_grant) prio_mem_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_mem_q <= 1'b1;
    else        prio_mem_q <= prio_mem_d;
  end

endmodule

// File: rtl/pim_ctrl.sv
// Sequencer for one bit-serial PIM macro: weight read/write plus LSB-first MAC
// jobs, all macro drive signals registered.
module pim_ctrl
  import pim_ctrl_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int PDEPTH = 1 << AWIDTH,
  parameter int PWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic                     mem_we,
  input  logic [AWIDTH-1:0]        mem_addr,
  input  logic [PWIDTH-1:0]        mem_wdata,
  output logic                     mem_rvalid,
  input  logic                     mem_rready,
  output logic [PWIDTH-1:0]        mem_rdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PDEPTH*IWIDTH-1:0] in_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DWIDTH-1:0]        res_data,
  output logic [AWIDTH-1:0]        pim_addr,
  output logic [PWIDTH-1:0]        pim_d,
  output logic                     pim_w_en,
  output logic                     pim_p_en,
  output logic [PDEPTH-1:0]        pim_rwl,
  input  logic [PWIDTH-1:0]        pim_q,
  input  logic [DWIDTH-1:0]        pim_mac_out
);

  // Shared phase counter: wide enough for the plane index and the fixed phases.
  localparam int CW = $clog2(IWIDTH) + 1;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [PDEPTH*IWIDTH-1:0]   in_lat_q, in_lat_d;
  logic [AWIDTH-1:0]          addr_q, addr_d;
  logic [PWIDTH-1:0]          wd_q, wd_d;
  logic                       w_en_q, w_en_d;
  logic                       p_en_q, p_en_d;
  logic [PDEPTH-1:0]          rwl_q, rwl_d;
  logic [PWIDTH-1:0]          rdata_q, rdata_d;
  logic                       rvalid_q, rvalid_d;
  logic [DWIDTH-1:0]          res_data_q, res_data_d;
  logic                       res_valid_q, res_valid_d;
  logic                       mem_grant, in_grant;

  pim_ctrl_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state_q == S_IDLE),
    .mem_valid (mem_valid),
    .in_valid  (in_valid),
    .mem_ready (mem_ready),
    .in_ready  (in_ready),
    .mem_grant (mem_grant),
    .in_grant  (in_grant)
  );

  function automatic logic [PDEPTH-1:0] plane(input logic [PDEPTH*IWIDTH-1:0] v,
                                              input int k);
    logic [PDEPTH-1:0] p;
    for (int j = 0; j < PDEPTH; j++) p[j] = v[j*IWIDTH + k];
    return p;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_lat_d    = in_lat_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    w_en_d      = 1'b0;
    p_en_d      = 1'b0;
    rwl_d       = '0;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (mem_grant) begin
          addr_d = mem_addr;
          if (mem_we) begin
            wd_d    = mem_wdata;
            w_en_d  = 1'b1;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else if (in_grant) begin
          // Inverted plane 0 forces a wordline edge so the ADC re-evaluates.
          in_lat_d = in_data;
          rwl_d    = ~plane(in_data, 0);
          cnt_d    = '0;
          state_d  = S_PREP;
        end
      end
      S_WR:      state_d = S_IDLE;
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rdata_d = pim_q;
        state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
        end else if (mem_rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_PREP: begin
        if (cnt_q == CW'(PREP_CYCLES - 1)) begin
          rwl_d   = plane(in_lat_q, 0);
          p_en_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_MAC;
        end else begin
          rwl_d = rwl_q;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MAC: begin
        if (cnt_q == CW'(IWIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          rwl_d  = plane(in_lat_q, int'(cnt_q) + 1);
          p_en_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          res_data_d  = pim_mac_out;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_lat_q    <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      w_en_q      <= 1'b0;
      p_en_q      <= 1'b0;
      rwl_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every flop samples pre-edge values together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_lat_q    <= in_lat_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      w_en_q      <= w_en_d;
      p_en_q      <= p_en_d;
      rwl_q       <= rwl_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign pim_addr   = addr_q;
  assign pim_d      = wd_q;
  assign pim_w_en   = w_en_q;
  assign pim_p_en   = p_en_q;
  assign pim_rwl    = rwl_q;
  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;

endmodule

// File: tb/tb_pim_ctrl.sv
// Self-checking bench for pim_ctrl with a behavioural bit-serial macro and an
// arithmetic dot-product reference.
module tb_pim_ctrl;

  localparam int AW = 2;
  localparam int PD = 4;
  localparam int PW = 4;
  localparam int IW = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mem_valid = 1'b0, mem_we = 1'b0, mem_rready = 1'b0;
  logic [AW-1:0]  mem_addr = '0;
  logic [PW-1:0]  mem_wdata = '0;
  logic           mem_ready, mem_rvalid;
  logic [PW-1:0]  mem_rdata;
  logic           in_valid = 1'b0, in_ready;
  logic [PD*IW-1:0] in_data = '0;
  logic           res_valid, res_ready = 1'b0;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  pim_addr;
  logic [PW-1:0]  pim_d;
  logic           pim_w_en, pim_p_en;
  logic [PD-1:0]  pim_rwl;
  logic [PW-1:0]  pim_q = '0;
  logic [DW-1:0]  pim_mac_out = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int excl_viol = 0;
  bit mon_grants = 1'b0;
  int grants[$];

  logic [PW-1:0] ref_w [PD] = '{default: '0};

  // Behavioural macro: registered read, LSB-first shift-accumulate while p_en,
  // result registered and accumulator cleared on the first p_en-low edge.
  logic [PW-1:0] wmem [PD] = '{default: '0};
  logic [DW-1:0] acc = '0;
  int            shift = 0;
  bit            run = 1'b0;

  always #5 clk = ~clk;

  pim_ctrl #(
    .AWIDTH(AW), .PDEPTH(PD), .PWIDTH(PW), .DWIDTH(DW), .IWIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .pim_addr(pim_addr), .pim_d(pim_d), .pim_w_en(pim_w_en), .pim_p_en(pim_p_en),
    .pim_rwl(pim_rwl), .pim_q(pim_q), .pim_mac_out(pim_mac_out)
  );

  function automatic logic [DW-1:0] macro_dot(input logic [PD-1:0] rwl);
    logic [DW-1:0] s = '0;
    for (int j = 0; j < PD; j++) if (rwl[j]) s += DW'(wmem[j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (pim_w_en) wmem[pim_addr] <= pim_d;
    pim_q <= wmem[pim_addr];
    if (pim_p_en) begin
      acc   <= acc + (macro_dot(pim_rwl) << shift);
      shift <= shift + 1;
      run   <= 1'b1;
    end else if (run) begin
      pim_mac_out <= acc;
      acc   <= '0;
      shift <= 0;
      run   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (pim_w_en && pim_p_en) excl_viol++;
    if (rst_n && mon_grants) begin
      if (mem_valid && mem_ready) grants.push_back(0);
      if (in_valid && in_ready)   grants.push_back(1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_mem);
    int t = 0;
    while (is_mem ? !mem_ready : !in_ready) begin
      tick();
      t++;
      if (t > 50) begin
        check("ready_timeout", 32'd0, 32'd1);
        finish_test();
        break;
      end
    end
  endtask

  function automatic logic [PD-1:0] tb_plane(input logic [PD*IW-1:0] v, input int k);
    logic [PD-1:0] p;
    for (int j = 0; j < PD; j++) p[j] = ((int'(v[j*IW +: IW]) >> k) % 2) == 1;
    return p;
  endfunction

  function automatic logic [DW-1:0] ref_mac(input logic [PD*IW-1:0] v);
    logic [DW-1:0] s = '0;
    for (int j = 0; j < PD; j++) s += DW'(v[j*IW +: IW]) * DW'(ref_w[j]);
    return s;
  endfunction

  task automatic mem_write(input logic [AW-1:0] a, input logic [PW-1:0] d);
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    wait_ready(1'b1);
    tick();
    mem_valid = 1'b0; mem_we = 1'b0;
    check("wr_wen",  32'(pim_w_en), 32'd1);
    check("wr_addr", 32'(pim_addr), 32'(a));
    check("wr_data", 32'(pim_d),    32'(d));
    check("wr_pen",  32'(pim_p_en), 32'd0);
    ref_w[a] = d;
    tick();
    check("wr_done",  32'(pim_w_en),  32'd0);
    check("wr_ready", 32'(mem_ready), 32'd1);
  endtask

  task automatic mem_read(input logic [AW-1:0] a, input int hold);
    logic [PW-1:0] exp;
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = a;
    wait_ready(1'b1);
    tick();
    mem_valid = 1'b0;
    mem_addr  = AW'($urandom);
    exp = ref_w[a];
    tick(); tick();
    check("rd_early", 32'(mem_rvalid), 32'd0);
    tick();
    check("rd_valid", 32'(mem_rvalid), 32'd1);
    check("rd_data",  32'(mem_rdata),  32'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("rd_hold_v", 32'(mem_rvalid), 32'd1);
      check("rd_hold_d", 32'(mem_rdata),  32'(exp));
    end
    mem_rready = 1'b1;
    tick();
    mem_rready = 1'b0;
    check("rd_release", 32'(mem_rvalid), 32'd0);
  endtask

  task automatic run_mac(input logic [PD*IW-1:0] v, input int hold);
    logic [DW-1:0] exp;
    logic [PD-1:0] prep;
    in_valid = 1'b1; in_data = v;
    wait_ready(1'b0);
    tick();
    in_valid = 1'b0;
    in_data  = (PD*IW)'($urandom);
    exp  = ref_mac(v);
    prep = ~tb_plane(v, 0);
    check("prep_pen", 32'(pim_p_en), 32'd0);
    check("prep_rwl", 32'(pim_rwl),  32'(prep));
    for (int k = 0; k < IW; k++) begin
      tick();
      check("mac_pen", 32'(pim_p_en), 32'd1);
      check("mac_rwl", 32'(pim_rwl),  32'(tb_plane(v, k)));
    end
    tick();
    check("drain_pen", 32'(pim_p_en), 32'd0);
    check("drain_rwl", 32'(pim_rwl),  32'd0);
    tick();
    check("res_early", 32'(res_valid), 32'd0);
    tick();
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data",  res_data,       exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("res_hold_v", 32'(res_valid), 32'd1);
      check("res_hold_d", res_data,       exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_release", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_test();
  end

  initial begin
    int t;
    #12;
    check("rst_addr",   32'(pim_addr),   32'd0);
    check("rst_d",      32'(pim_d),      32'd0);
    check("rst_wen",    32'(pim_w_en),   32'd0);
    check("rst_pen",    32'(pim_p_en),   32'd0);
    check("rst_rwl",    32'(pim_rwl),    32'd0);
    check("rst_rvalid", 32'(mem_rvalid), 32'd0);
    check("rst_rdata",  32'(mem_rdata),  32'd0);
    check("rst_resv",   32'(res_valid),  32'd0);
    check("rst_resd",   res_data,        32'd0);
    check("rst_mready", 32'(mem_ready),  32'd1);
    check("rst_iready", 32'(in_ready),   32'd1);
    mem_valid = 1'b1; in_valid = 1'b1;
    #1;
    check("rst_prio_m", 32'(mem_ready), 32'd1);
    check("rst_prio_i", 32'(in_ready),  32'd0);

    // Both requesters pending straight out of reset.
    mem_we = 1'b1; mem_addr = 2'd3; mem_wdata = 4'd4;
    in_data = 16'h1111; res_ready = 1'b1;
    ref_w[3] = 4'd4;
    mon_grants = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (40) tick();
    mem_valid = 1'b0; in_valid = 1'b0;
    t = 0;
    while (!mem_ready && t < 40) begin tick(); t++; end
    check("arb_drain", 32'(mem_ready), 32'd1);
    mon_grants = 1'b0;
    res_ready = 1'b0; mem_we = 1'b0;
    check("arb_count", 32'(grants.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check("arb_order", 32'(grants[i]), 32'(i % 2));

    for (int r = 0; r < PD; r++) mem_write(AW'(r), PW'(r + 1));
    mem_read(2'd2, 5);

    run_mac(16'h1111, 0);
    run_mac(16'hFFFF, 0);
    run_mac(16'h000F, 0);

    // Abort during plane 2.
    in_valid = 1'b1; in_data = 16'h1111;
    wait_ready(1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("abort_pre_pen", 32'(pim_p_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pen",   32'(pim_p_en),   32'd0);
    check("abort_rwl",   32'(pim_rwl),    32'd0);
    check("abort_wen",   32'(pim_w_en),   32'd0);
    check("abort_addr",  32'(pim_addr),   32'd0);
    check("abort_resv",  32'(res_valid),  32'd0);
    check("abort_rvld",  32'(mem_rvalid), 32'd0);
    check("abort_mready", 32'(mem_ready), 32'd1);
    #3 rst_n = 1'b1;
    tick();
    run_mac(16'h1111, 0);

    mem_write(2'd0, 4'hF);
    run_mac(16'h1111, 5);
    run_mac(16'h0001, 0);

    repeat (30) begin
      case ($urandom_range(0, 2))
        0:       mem_write(AW'($urandom), PW'($urandom));
        1:       mem_read(AW'($urandom), int'($urandom_range(0, 3)));
        default: run_mac((PD*IW)'($urandom), int'($urandom_range(0, 3)));
      endcase
    end

    check("excl_wen_pen", 32'(excl_viol), 32'd0);
    finish_test();
  end

endmodule
